// File: rtl/png_chunk_packer.sv
// Purpose: wraps a zlib byte stream into a PNG file (signature, IHDR, IDAT chunks, IEND) with lengths and CRC32.
// Latency: first output byte is valid the cycle after start_i; sustained 1 byte/cycle out while rdy_i is high.
// Backpressure: output holds dat_o/lst_o while rdy_i is low; input is taken only while buffering a chunk.
// Ports: clk/rstn (async, active-high); cfg_w_i/cfg_h_i/cfg_clr_i image config latched on start_i;
//        val_i/dat_i/lst_i/rdy_o zlib byte input; val_o/dat_o/lst_o/rdy_i PNG byte output; done_o end pulse.
module png_chunk_packer #(
   parameter int CHUNK_SIZE = 1024,
   parameter int CNT_WD     = 11,
   parameter int W_WD       = 16,
   parameter int BIT_DEPTH  = 8
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic [W_WD-1:0] cfg_w_i,
   input  logic [W_WD-1:0] cfg_h_i,
   input  logic [2:0]      cfg_clr_i,
   input  logic            start_i,
   output logic            done_o,
   input  logic            val_i,
   input  logic [7:0]      dat_i,
   input  logic            lst_i,
   output logic            rdy_o,
   output logic            val_o,
   output logic [7:0]      dat_o,
   output logic            lst_o,
   input  logic            rdy_i
);

   localparam int AW = (CHUNK_SIZE > 1) ? $clog2(CHUNK_SIZE) : 1;
   // byte index must reach 24 inside IHDR as well as cnt inside IDAT data
   localparam int IW = (CNT_WD > 5) ? CNT_WD : 5;
   localparam logic [CNT_WD-1:0] CS     = CNT_WD'(CHUNK_SIZE);
   localparam logic [7:0]        BD     = 8'(BIT_DEPTH);
   localparam logic [63:0]       SIG_C  = 64'h89504E47_0D0A1A0A;
   localparam logic [95:0]       IEND_C = 96'h00000000_49454E44_AE426082;

   typedef enum logic [3:0] {
      S_IDLE, S_SIG, S_IHDR, S_FILL, S_IDAT_HDR, S_IDAT_DAT, S_IDAT_CRC, S_IEND, S_DONE
   } state_t;

   state_t            state, state_nxt;
   logic [IW-1:0]     idx;
   logic [IW-1:0]     cnt_ext;
   logic [CNT_WD-1:0] cnt;
   logic              lst_seen;
   logic [31:0]       crc;
   logic [31:0]       crc_fin;
   logic [W_WD-1:0]   w_q, h_q;
   logic [2:0]        clr_q;
   logic [31:0]       w32, h32, len32;
   logic [7:0]        mem [0:(1<<AW)-1];
   logic [7:0]        rd_dat;
   logic [AW-1:0]     rd_addr;
   logic              out_hs, in_hs, crc_en, crc_init;

   function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'd0, d};
      for (int i = 0; i < 8; i++) begin
         r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      end
      return r;
   endfunction

   assign out_hs  = val_o && rdy_i;
   assign in_hs   = val_i && rdy_o;
   assign cnt_ext = IW'(cnt);
   assign crc_fin = ~crc;
   assign w32     = 32'(w_q);
   assign h32     = 32'(h_q);
   assign len32   = 32'(cnt);

   // Prefetch: rd_dat always holds the byte that is on dat_o this cycle.
   // During the IDAT header it preloads entry 0; in the data phase it reads
   // one ahead whenever the current byte is consumed.
   always_comb begin
      rd_addr = '0;
      if (state == S_IDAT_DAT) begin
         rd_addr = idx[AW-1:0] + AW'(out_hs);
      end
   end

   always_ff @(posedge clk) begin
      if (in_hs) begin
         mem[cnt[AW-1:0]] <= dat_i;
      end
      rd_dat <= mem[rd_addr];
   end

   // FSM state register
   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next state
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:     if (start_i) state_nxt = S_SIG;
         S_SIG:      if (out_hs && idx[2:0] == 3'd7) state_nxt = S_IHDR;
         S_IHDR:     if (out_hs && idx[4:0] == 5'd24) state_nxt = S_FILL;
         S_FILL:     if (in_hs && (lst_i || (cnt + 1'b1) == CS)) state_nxt = S_IDAT_HDR;
         S_IDAT_HDR: if (out_hs && idx[2:0] == 3'd7) state_nxt = S_IDAT_DAT;
         S_IDAT_DAT: if (out_hs && idx == cnt_ext - 1'b1) state_nxt = S_IDAT_CRC;
         S_IDAT_CRC: if (out_hs && idx[1:0] == 2'd3) state_nxt = lst_seen ? S_IEND : S_FILL;
         S_IEND:     if (out_hs && idx[3:0] == 4'd11) state_nxt = S_DONE;
         S_DONE:     state_nxt = S_IDLE;
         default:    state_nxt = S_IDLE;
      endcase
   end

   // FSM outputs; every output is a function of registered state so it
   // holds steady across a stall
   always_comb begin
      val_o    = 1'b0;
      rdy_o    = 1'b0;
      dat_o    = 8'h00;
      lst_o    = 1'b0;
      done_o   = 1'b0;
      crc_en   = 1'b0;
      crc_init = 1'b0;
      case (state)
         S_SIG: begin
            val_o = 1'b1;
            dat_o = SIG_C[{~idx[2:0], 3'b000} +: 8];
         end
         S_IHDR: begin
            val_o    = 1'b1;
            crc_en   = (idx[4:0] >= 5'd4) && (idx[4:0] <= 5'd20);
            crc_init = (idx[4:0] == 5'd4);
            case (idx[4:0])
               5'd3:    dat_o = 8'h0D;
               5'd4:    dat_o = 8'h49;
               5'd5:    dat_o = 8'h48;
               5'd6:    dat_o = 8'h44;
               5'd7:    dat_o = 8'h52;
               5'd8:    dat_o = w32[31:24];
               5'd9:    dat_o = w32[23:16];
               5'd10:   dat_o = w32[15:8];
               5'd11:   dat_o = w32[7:0];
               5'd12:   dat_o = h32[31:24];
               5'd13:   dat_o = h32[23:16];
               5'd14:   dat_o = h32[15:8];
               5'd15:   dat_o = h32[7:0];
               5'd16:   dat_o = BD;
               5'd17:   dat_o = {5'd0, clr_q};
               5'd21:   dat_o = crc_fin[31:24];
               5'd22:   dat_o = crc_fin[23:16];
               5'd23:   dat_o = crc_fin[15:8];
               5'd24:   dat_o = crc_fin[7:0];
               default: dat_o = 8'h00;
            endcase
         end
         S_FILL: rdy_o = 1'b1;
         S_IDAT_HDR: begin
            val_o    = 1'b1;
            crc_en   = idx[2];
            crc_init = (idx[2:0] == 3'd4);
            case (idx[2:0])
               3'd0:    dat_o = len32[31:24];
               3'd1:    dat_o = len32[23:16];
               3'd2:    dat_o = len32[15:8];
               3'd3:    dat_o = len32[7:0];
               3'd4:    dat_o = 8'h49;
               3'd5:    dat_o = 8'h44;
               3'd6:    dat_o = 8'h41;
               default: dat_o = 8'h54;
            endcase
         end
         S_IDAT_DAT: begin
            val_o  = 1'b1;
            crc_en = 1'b1;
            dat_o  = rd_dat;
         end
         S_IDAT_CRC: begin
            val_o = 1'b1;
            dat_o = crc_fin[{~idx[1:0], 3'b000} +: 8];
         end
         S_IEND: begin
            val_o = 1'b1;
            dat_o = IEND_C[(7'd88 - {idx[3:0], 3'b000}) +: 8];
            lst_o = (idx[3:0] == 4'd11);
         end
         S_DONE: done_o = 1'b1;
         default: ;
      endcase
   end

   // Datapath: byte index within the current section, fill count, CRC, config
   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         idx      <= '0;
         cnt      <= '0;
         lst_seen <= 1'b0;
         crc      <= '0;
         w_q      <= '0;
         h_q      <= '0;
         clr_q    <= '0;
      end else begin
         if (state_nxt != state) begin
            idx <= '0;
         end else if (out_hs) begin
            idx <= idx + 1'b1;
         end
         if (state == S_IDLE && start_i) begin
            w_q      <= cfg_w_i;
            h_q      <= cfg_h_i;
            clr_q    <= cfg_clr_i;
            lst_seen <= 1'b0;
            cnt      <= '0;
         end
         if (in_hs) begin
            cnt <= cnt + 1'b1;
            if (lst_i) begin
               lst_seen <= 1'b1;
            end
         end
         if (state == S_IDAT_CRC && state_nxt != state) begin
            cnt <= '0;
         end
         // CRC restarts on the first chunk-type byte and is left untouched
         // while its own bytes are being emitted
         if (out_hs && crc_en) begin
            crc <= crc_step(crc_init ? 32'hFFFFFFFF : crc, dat_o);
         end
      end
   end

endmodule
